// File: rtl/serial_comp_ctrl_if.sv
// rtl/serial_comp_ctrl_if.sv - request/result bundle between requester and bit-serial comparator
interface serial_comp_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             lt;
    logic             gt;
    logic [CW-1:0]    cmp_cycles;

    // Requesting control block
    modport master (
        output start, a, b,
        input  busy, done, eq, lt, gt, cmp_cycles
    );

    // Comparator sequencer
    modport slave (
        input  start, a, b,
        output busy, done, eq, lt, gt, cmp_cycles
    );
endinterface

// File: rtl/serial_comp_ctrl.sv
// rtl/serial_comp_ctrl.sv - MSB-first bit-serial magnitude comparator sequencer
module serial_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_comp_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;
    logic [CW-1:0]    r_cmp_cycles;

    // 1-bit comparator slice, always looking at the current MSB pair
    logic w_sa_msb;
    logic w_sb_msb;
    logic w_bit_ne;

    assign w_sa_msb = r_sa[WIDTH-1];
    assign w_sb_msb = r_sb[WIDTH-1];
    assign w_bit_ne = w_sa_msb ^ w_sb_msb;

    // Sequencer: capture, walk bits MSB first, stop on first difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sa         <= '0;
            r_sb         <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_eq         <= 1'b0;
            r_lt         <= 1'b0;
            r_gt         <= 1'b0;
            r_cmp_cycles <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_busy  <= 1'b1;
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (w_bit_ne) begin
                        // Result flags change only at this decision edge
                        r_gt         <= w_sa_msb & ~w_sb_msb;
                        r_lt         <= ~w_sa_msb & w_sb_msb;
                        r_eq         <= 1'b0;
                        r_cmp_cycles <= CW'(WIDTH) - r_cnt;
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end else if (r_cnt == '0) begin
                        r_eq         <= 1'b1;
                        r_lt         <= 1'b0;
                        r_gt         <= 1'b0;
                        r_cmp_cycles <= CW'(WIDTH);
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
                        r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    // One gap cycle; start is not looked at here
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.eq         = r_eq;
    assign bus.lt         = r_lt;
    assign bus.gt         = r_gt;
    assign bus.cmp_cycles = r_cmp_cycles;
endmodule

// File: tb/tb_serial_comp_ctrl.sv
// tb/tb_serial_comp_ctrl.sv - directed-vector bench for serial_comp_ctrl
module tb_serial_comp_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    serial_comp_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_comp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // res = {eq, lt, gt}; p = MSB-first index of first differing bit
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input int p, input logic [2:0] res);
        int n;
        bus.start = 1'b1;
        bus.a     = va;
        bus.b     = vb;
        tick();
        bus.start = 1'b0;
        bus.a     = ~va;
        bus.b     = vb ^ 8'h5C;
        check({tag, "_busy_acc"}, 64'(bus.busy), 64'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.done && n < WIDTH + 4);
        check({tag, "_latency"}, 64'(n), 64'(p + 1));
        check({tag, "_result"}, 64'({bus.eq, bus.lt, bus.gt}), 64'(res));
        check({tag, "_cycles"}, 64'(bus.cmp_cycles), 64'(p + 1));
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
        tick();
        check({tag, "_done_fall"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_flags", 64'({bus.done, bus.eq, bus.lt, bus.gt}), 64'd0);
            check("rst_cycles", 64'(bus.cmp_cycles), 64'd0);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        check("idle_busy", 64'(bus.busy), 64'd0);

        run_op("msb_exit", 8'hA5, 8'h25, 0, 3'b001);
        run_op("lsb_lt",   8'h3C, 8'h3D, 7, 3'b010);
        run_op("equal",    8'h5A, 8'h5A, 7, 3'b100);
        run_op("eq_clear", 8'h10, 8'h00, 3, 3'b001);

        // Busy collision with start held high throughout
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h80;
        tick();
        bus.a = 8'hFF;
        bus.b = 8'h00;
        tick();
        check("coll_done", 64'(bus.done), 64'd1);
        check("coll_result", 64'({bus.eq, bus.lt, bus.gt}), 64'b010);
        check("coll_cycles", 64'(bus.cmp_cycles), 64'd1);
        tick();
        check("coll_gap_busy", 64'(bus.busy), 64'd0);
        check("coll_gap_done", 64'(bus.done), 64'd0);
        tick();
        check("coll_reaccept", 64'(bus.busy), 64'd1);
        check("coll_reacc_done", 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        tick();
        check("coll2_done", 64'(bus.done), 64'd1);
        check("coll2_result", 64'({bus.eq, bus.lt, bus.gt}), 64'b001);
        check("coll2_cycles", 64'(bus.cmp_cycles), 64'd1);
        tick();
        check("coll2_idle", 64'(bus.busy), 64'd0);

        // Reset in the middle of an equal-operand compare
        bus.start = 1'b1;
        bus.a     = 8'hC3;
        bus.b     = 8'hC3;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("mid_busy_pre", 64'(bus.busy), 64'd1);
        check("mid_gt_held", 64'(bus.gt), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_busy_rst", 64'(bus.busy), 64'd0);
        check("mid_flags_rst", 64'({bus.done, bus.eq, bus.lt, bus.gt}), 64'd0);
        check("mid_cycles_rst", 64'(bus.cmp_cycles), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_idle", 64'(bus.busy), 64'd0);
        run_op("post_rst", 8'h02, 8'h01, 6, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
